// File: rtl/exec_controller_pkg.sv
// Shared definitions for the exec run/step controller: state and phase codes, widths
// and the registered output bundle.
package exec_controller_pkg;

  localparam int unsigned NUM_PHASES = 4;
  localparam int unsigned PHASE_W    = $clog2(NUM_PHASES);
  localparam int unsigned DB_CNT_W   = 16;
  localparam int unsigned DIV_W      = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_HALT = 2'd3
  } ctrl_state_e;

  typedef enum logic [PHASE_W-1:0] {
    PH_FETCH     = 2'd0,
    PH_DECODE    = 2'd1,
    PH_EXECUTE   = 2'd2,
    PH_WRITEBACK = 2'd3
  } phase_e;

  typedef struct packed {
    ctrl_state_e        state;
    logic [PHASE_W-1:0] phase;
    logic               cpu_enable;
    logic               running;
  } ctrl_out_t;

  // Terminal divider count; a divide of 0 behaves like a divide of 1.
  function automatic logic [DIV_W-1:0] div_last(input logic [DIV_W-1:0] run_div);
    return (run_div == '0) ? '0 : run_div - DIV_W'(1);
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Push-button conditioner: 2-FF synchroniser, stable-sample counter and a one-cycle
// pulse on each accepted 0->1 change of the debounced level.
module button_debouncer
  import exec_controller_pkg::*;
#(
  parameter logic [DB_CNT_W-1:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic press
);

  localparam logic [DB_CNT_W-1:0] CNT_LAST =
    (DEBOUNCE_CYCLES == '0) ? '0 : DEBOUNCE_CYCLES - DB_CNT_W'(1);

  logic                sync_q1;
  logic                sync_q2;
  logic                level_q;
  logic [DB_CNT_W-1:0] cnt_q;

  // Level flips on the DEBOUNCE_CYCLES-th consecutive sample that disagrees with it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press   <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
      press   <= 1'b0;
      if (sync_q2 == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_q <= sync_q2;
        press   <= sync_q2;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + DB_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/exec_controller.sv
// Run/step sequencer: owns IDLE/RUN/STEP/HALT, the RUN-mode divider and the 4-phase
// counter, and issues the registered per-cycle cpu_enable.
module exec_controller
  import exec_controller_pkg::*;
#(
  parameter logic [DB_CNT_W-1:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [DIV_W-1:0]    RUN_DIV         = 24'd1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               exec,
  input  logic               step_mode,
  input  logic               halt_req,
  output logic               cpu_enable,
  output logic [PHASE_W-1:0] phase,
  output logic [1:0]         ctrl_state,
  output logic               running
);

  localparam logic [DIV_W-1:0] DIV_LAST = div_last(RUN_DIV);

  ctrl_out_t        out_q;
  ctrl_out_t        out_d;
  logic             pause_q;
  logic             pause_d;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic             exec_press;
  logic             boundary;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_exec_db (
    .clock(clock),
    .reset(reset),
    .raw  (exec),
    .press(exec_press)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_q   <= '{state: ST_IDLE, phase: '0, cpu_enable: 1'b0, running: 1'b0};
      pause_q <= 1'b0;
      div_q   <= '0;
    end else begin
      out_q   <= out_d;
      pause_q <= pause_d;
      div_q   <= div_d;
    end
  end

  // Boundary is the enabled writeback cycle; halt wins over pause and over returning to IDLE.
  always_comb begin
    out_d    = out_q;
    pause_d  = pause_q;
    div_d    = '0;
    boundary = out_q.cpu_enable && (out_q.phase == PHASE_W'(PH_WRITEBACK));
    if (out_q.cpu_enable) begin
      out_d.phase = out_q.phase + PHASE_W'(1);
    end
    unique case (out_q.state)
      ST_IDLE: begin
        if (exec_press) begin
          out_d.state = step_mode ? ST_STEP : ST_RUN;
        end
      end
      ST_STEP: begin
        if (boundary) begin
          out_d.state = halt_req ? ST_HALT : ST_IDLE;
        end
      end
      ST_RUN: begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        if (boundary) begin
          if (halt_req) begin
            out_d.state = ST_HALT;
          end else if (pause_q || exec_press) begin
            out_d.state = ST_IDLE;
          end
        end else if (exec_press) begin
          pause_d = 1'b1;
        end
      end
      ST_HALT: begin
        out_d.phase = '0;
      end
      default: begin
        out_d.state = ST_IDLE;
      end
    endcase
    if (out_d.state != ST_RUN) begin
      pause_d = 1'b0;
      div_d   = '0;
    end
    out_d.cpu_enable = (out_d.state == ST_STEP) ||
                       ((out_d.state == ST_RUN) && (div_d == DIV_LAST));
    out_d.running    = (out_d.state == ST_RUN) || (out_d.state == ST_STEP);
  end

  assign cpu_enable = out_q.cpu_enable;
  assign phase      = out_q.phase;
  assign ctrl_state = out_q.state;
  assign running    = out_q.running;

endmodule

// File: tb/tb_exec_controller.sv
// Scoreboard bench for exec_controller (DEBOUNCE_CYCLES=4, RUN_DIV=2): every expected
// enable {state, phase} is queued up front and popped by a monitor on each cpu_enable.
module tb_exec_controller;
  import exec_controller_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       exec = 1'b0;
  logic       step_mode = 1'b0;
  logic       halt_req = 1'b0;
  logic       cpu_enable;
  logic [1:0] phase;
  logic [1:0] ctrl_state;
  logic       running;

  int         n_vec = 0;
  int         n_err = 0;
  int         n_en_seen = 0;
  logic [3:0] exp_q[$];
  logic [3:0] mon_e;
  logic       prev_en = 1'b0;

  exec_controller #(
    .DEBOUNCE_CYCLES(16'd4),
    .RUN_DIV        (24'd2)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .exec      (exec),
    .step_mode (step_mode),
    .halt_req  (halt_req),
    .cpu_enable(cpu_enable),
    .phase     (phase),
    .ctrl_state(ctrl_state),
    .running   (running)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // One full instruction worth of enables in the given state.
  task automatic push_instr(input logic [1:0] st);
    for (int p = 0; p < 4; p++) exp_q.push_back({st, 2'(p)});
  endtask

  // Assumes exec was just raised; holds it, releases it, lets the level settle low.
  task automatic hold_release();
    tick(10);
    exec = 1'b0;
    tick(10);
  endtask

  task automatic press_button();
    exec = 1'b1;
    hold_release();
  endtask

  task automatic wait_en_phase(input logic [1:0] p, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clock);
      hit = cpu_enable && (phase == p);
    end
    check(name, int'(hit), 1);
  endtask

  task automatic wait_state(input logic [1:0] s, input string name);
    for (int i = 0; i < 200 && ctrl_state != s; i++) @(negedge clock);
    check(name, int'(ctrl_state), int'(s));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(2);
    halt_req = 1'b0;
    reset = 1'b1;
    tick(2);
  endtask

  // Monitor: every enabled cycle must match the next queued {state, phase}.
  initial begin
    forever begin
      @(negedge clock);
      if (reset && cpu_enable) begin
        n_en_seen++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_enable: state %0d phase %0d, expected no enable",
                   ctrl_state, phase);
        end else begin
          mon_e = exp_q.pop_front();
          check("enable_state_phase", int'({ctrl_state, phase}), int'(mon_e));
          check("running_flag", int'(running), 1);
          if (ctrl_state == 2'd1) check("run_enable_gap", int'(prev_en), 0);
        end
      end
      prev_en = reset && cpu_enable;
    end
  end

  initial begin
    int mark;
    tick(3);
    check("reset_state", int'(ctrl_state), 0);
    check("reset_phase", int'(phase), 0);
    check("reset_enable", int'(cpu_enable), 0);
    check("reset_running", int'(running), 0);
    reset = 1'b1;
    tick(2);

    // Bouncy press in step mode: one press, one instruction
    step_mode = 1'b1;
    push_instr(2'd2);
    exec = 1'b1; tick(1); exec = 1'b0; tick(1);
    exec = 1'b1; tick(1); exec = 1'b0; tick(1);
    exec = 1'b1; tick(20); exec = 1'b0; tick(10);
    wait_state(2'd0, "step_back_to_idle");
    check("step_idle_phase", int'(phase), 0);
    check("step_idle_running", int'(running), 0);
    check("step_enable_count", exp_q.size(), 0);

    // Run, then pause pressed at phase 1 of the fourth instruction
    step_mode = 1'b0;
    repeat (4) push_instr(2'd1);
    press_button();
    check("run_running", int'(running), 1);
    wait_en_phase(2'd2, "run_find_phase2");
    exec = 1'b1;
    hold_release();
    wait_state(2'd0, "pause_to_idle");
    check("pause_phase", int'(phase), 0);
    check("pause_enable_count", exp_q.size(), 0);

    // Press lands on the enabled phase-3 cycle: stop right there
    repeat (3) push_instr(2'd1);
    press_button();
    wait_en_phase(2'd0, "bnd_find_phase0");
    exec = 1'b1;
    hold_release();
    wait_state(2'd0, "bnd_press_idle");
    check("bnd_press_count", exp_q.size(), 0);

    // Same coincidence with halt_req: halt wins
    repeat (3) push_instr(2'd1);
    press_button();
    wait_en_phase(2'd0, "bndh_find_phase0");
    halt_req = 1'b1;
    exec = 1'b1;
    hold_release();
    wait_state(2'd3, "bnd_halt_state");
    check("bnd_halt_count", exp_q.size(), 0);
    do_reset();
    check("after_reset_state", int'(ctrl_state), 0);

    // halt_req raised during phase 1 and held; HALT ignores presses
    repeat (3) push_instr(2'd1);
    press_button();
    wait_en_phase(2'd1, "halt_find_phase1");
    halt_req = 1'b1;
    wait_state(2'd3, "halt_state");
    check("halt_enable_count", exp_q.size(), 0);
    mark = n_en_seen;
    press_button();
    press_button();
    tick(60);
    check("halt_no_enables", n_en_seen - mark, 0);
    check("halt_stays", int'(ctrl_state), 3);
    check("halt_phase", int'(phase), 0);
    check("halt_running", int'(running), 0);
    do_reset();

    // Asynchronous reset in the middle of an instruction
    repeat (3) push_instr(2'd1);
    press_button();
    wait_en_phase(2'd2, "rst_find_phase2");
    #1;
    reset = 1'b0;
    #1;
    check("midrun_reset_state", int'(ctrl_state), 0);
    check("midrun_reset_phase", int'(phase), 0);
    check("midrun_reset_enable", int'(cpu_enable), 0);
    check("midrun_reset_running", int'(running), 0);
    check("midrun_leftover", exp_q.size(), 1);
    exp_q.delete();
    tick(2);
    reset = 1'b1;
    tick(2);

    // Step with halt on phase 3, then reset and a normal step
    step_mode = 1'b1;
    push_instr(2'd2);
    exec = 1'b1;
    wait_en_phase(2'd3, "stephalt_find_phase3");
    halt_req = 1'b1;
    tick(10);
    exec = 1'b0;
    tick(10);
    check("step_halt_state", int'(ctrl_state), 3);
    check("step_halt_count", exp_q.size(), 0);
    do_reset();
    push_instr(2'd2);
    press_button();
    wait_state(2'd0, "resume_step_idle");
    check("resume_step_count", exp_q.size(), 0);
    check("resume_step_phase", int'(phase), 0);
    tick(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
